adt7410_sensor_ctrl: RTL and testbench

ADT7410_SENSOR_CTRL -- requirements
Module: adt7410_sensor_ctrl

---
 rtl/sensor_ctrl_pkg.sv | 13 +
 rtl/interval_timer.sv | 36 +++
 rtl/adt7410_sensor_ctrl.sv | 111 +++++++++++
 tb/tb_adt7410_sensor_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sensor_ctrl_pkg.sv
// Shared types and constants for the ADT7410 periodic measurement controller.
package sensor_ctrl_pkg;

    localparam int TIMER_W = 32;

    typedef enum logic [1:0] {
        stDisabled = 2'd0,
        stIdle     = 2'd1,
        stXfer     = 2'd2,
        stNotify   = 2'd3
    } state_e;

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter that paces measurements; zero_o flags an expired interval.
module interval_timer
    import sensor_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic               dec_en_i,
    input  logic [TIMER_W-1:0] preset_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    assign zero_o = (count_q == '0);

    // Load wins over decrement; the count parks at zero until reloaded.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = preset_i;
        end else if (dec_en_i && !zero_o) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adt7410_sensor_ctrl.sv
// Periodically triggers an I2C temperature read and raises an interrupt when the
// reading moves by more than a programmable threshold from the last reported value.
module adt7410_sensor_ctrl
    import sensor_ctrl_pkg::*;
(
    input  logic        Clk_i,
    input  logic        Reset_n_i,
    input  logic        Enable_i,
    output logic        CpuIntr_o,
    output logic [15:0] SensorValue_o,
    output logic        MeasureFSM_Start_o,
    input  logic        MeasureFSM_Done_i,
    input  logic        MeasureFSM_Error_i,
    input  logic [7:0]  MeasureFSM_Byte0_i,
    input  logic [7:0]  MeasureFSM_Byte1_i,
    input  logic [15:0] ParamThreshold_i,
    input  logic [15:0] ParamCounterPresetH_i,
    input  logic [15:0] ParamCounterPresetL_i
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] sensor_value_q;
    logic [15:0] sensor_value_d;

    logic        timer_load;
    logic        timer_dec_en;
    logic        timer_zero;

    logic [15:0] new_value;
    logic [16:0] new_ext;
    logic [16:0] old_ext;
    logic [16:0] abs_diff;
    logic        exceeds;

    interval_timer u_timer (
        .clk_i    (Clk_i),
        .rst_n_i  (Reset_n_i),
        .load_i   (timer_load),
        .dec_en_i (timer_dec_en),
        .preset_i ({ParamCounterPresetH_i, ParamCounterPresetL_i}),
        .zero_o   (timer_zero)
    );

    // Widened to 17 bits and ordered before subtracting so the magnitude never wraps.
    assign new_value = {MeasureFSM_Byte1_i, MeasureFSM_Byte0_i};
    assign new_ext   = {1'b0, new_value};
    assign old_ext   = {1'b0, sensor_value_q};
    assign abs_diff  = (new_ext >= old_ext) ? (new_ext - old_ext) : (old_ext - new_ext);
    assign exceeds   = (abs_diff > {1'b0, ParamThreshold_i});

    always_comb begin
        state_d            = state_q;
        sensor_value_d     = sensor_value_q;
        timer_load         = 1'b1;
        timer_dec_en       = 1'b0;
        MeasureFSM_Start_o = 1'b0;
        CpuIntr_o          = 1'b0;

        unique case (state_q)
            stDisabled: begin
                if (Enable_i) begin
                    state_d = stIdle;
                end
            end
            stIdle: begin
                timer_load   = 1'b0;
                timer_dec_en = 1'b1;
                if (!Enable_i) begin
                    state_d = stDisabled;
                end else if (timer_zero) begin
                    MeasureFSM_Start_o = 1'b1;
                    state_d            = stXfer;
                end
            end
            stXfer: begin
                // Enable is only honoured once the transaction has finished.
                if (MeasureFSM_Error_i) begin
                    state_d = Enable_i ? stIdle : stDisabled;
                end else if (MeasureFSM_Done_i) begin
                    if (exceeds) begin
                        sensor_value_d = new_value;
                        state_d        = stNotify;
                    end else begin
                        state_d = Enable_i ? stIdle : stDisabled;
                    end
                end
            end
            stNotify: begin
                CpuIntr_o = 1'b1;
                state_d   = Enable_i ? stIdle : stDisabled;
            end
            default: begin
                state_d = stDisabled;
            end
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q        <= stDisabled;
            sensor_value_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            sensor_value_q <= sensor_value_d;
        end
    end

    assign SensorValue_o = sensor_value_q;

endmodule

// File: tb/tb_adt7410_sensor_ctrl.sv
// Directed bench: table of measurement transactions plus hand-written enable/reset sequences.
module tb_adt7410_sensor_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        intr;
    logic [15:0] value;
    logic        start;
    logic        done;
    logic        error;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [15:0] thr;
    logic [15:0] preset_h;
    logic [15:0] preset_l;

    int tests_run = 0;
    int fails     = 0;
    int start_cnt = 0;

    typedef struct {
        logic [15:0] thr;
        logic [15:0] new_val;
        logic        done;
        logic        err;
        logic        exp_intr;
        logic [15:0] exp_val;
    } vec_t;

    vec_t vecs[11];

    adt7410_sensor_ctrl dut (
        .Clk_i                 (clk),
        .Reset_n_i             (rst_n),
        .Enable_i              (enable),
        .CpuIntr_o             (intr),
        .SensorValue_o         (value),
        .MeasureFSM_Start_o    (start),
        .MeasureFSM_Done_i     (done),
        .MeasureFSM_Error_i    (error),
        .MeasureFSM_Byte0_i    (byte0),
        .MeasureFSM_Byte1_i    (byte1),
        .ParamThreshold_i      (thr),
        .ParamCounterPresetH_i (preset_h),
        .ParamCounterPresetL_i (preset_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) start_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(input int budget, output int cyc, output bit found);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (start) found = 1'b1;
        end
    endtask

    initial begin
        int  cyc;
        bit  found;
        bit  prev_rep;
        int  snap;

        vecs[0]  = '{16'd16,    16'h0C80, 1'b1, 1'b0, 1'b1, 16'h0C80};
        vecs[1]  = '{16'd16,    16'h0C90, 1'b1, 1'b0, 1'b0, 16'h0C80};
        vecs[2]  = '{16'd16,    16'h0C6F, 1'b1, 1'b0, 1'b1, 16'h0C6F};
        vecs[3]  = '{16'h0000,  16'h0C80, 1'b1, 1'b0, 1'b1, 16'h0C80};
        vecs[4]  = '{16'h0100,  16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[5]  = '{16'h0000,  16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{16'h0000,  16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[7]  = '{16'h0000,  16'h5678, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[8]  = '{16'hFFFF,  16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{16'hFFFE,  16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF};
        vecs[10] = '{16'h7FFF,  16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};

        // Reset with preset 5 and Enable high from the start.
        rst_n    = 1'b0;
        enable   = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        byte0    = 8'h00;
        byte1    = 8'h00;
        thr      = 16'd16;
        preset_h = 16'd0;
        preset_l = 16'd5;
        repeat (3) @(negedge clk);
        check("reset_intr", 32'(intr), 32'd0);
        check("reset_start", 32'(start), 32'd0);
        check("reset_value", 32'(value), 32'd0);
        rst_n = 1'b1;

        // Start must appear on the 6th stIdle cycle and not before.
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("preset5_start_c%0d", k), 32'(start), (k == 6) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("xfer_no_start", 32'(start), 32'd0);
        enable = 1'b0;
        error  = 1'b1;
        @(negedge clk);
        error = 1'b0;
        check("err_intr", 32'(intr), 32'd0);
        check("err_value", 32'(value), 32'd0);

        // A Done strobe while disabled must be ignored.
        thr   = 16'h0000;
        byte1 = 8'hFF;
        byte0 = 8'hFF;
        done  = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("ignored_done_value", 32'(value), 32'd0);
        check("ignored_done_intr", 32'(intr), 32'd0);
        check("single_start", 32'(start_cnt), 32'd1);

        // Table of transactions with preset 2.
        preset_l = 16'd2;
        enable   = 1'b1;
        prev_rep = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wait_start(20, cyc, found);
            check($sformatf("start_found[%0d]", i), 32'(found), 32'd1);
            if (!found) continue;
            check($sformatf("start_gap[%0d]", i), 32'(cyc), (i == 0) ? 32'd3 : (prev_rep ? 32'd2 : 32'd1));
            @(negedge clk);
            check($sformatf("start_in_xfer[%0d]", i), 32'(start), 32'd0);
            thr   = vecs[i].thr;
            byte1 = vecs[i].new_val[15:8];
            byte0 = vecs[i].new_val[7:0];
            done  = vecs[i].done;
            error = vecs[i].err;
            @(negedge clk);
            done  = 1'b0;
            error = 1'b0;
            check($sformatf("intr[%0d]", i), 32'(intr), 32'(vecs[i].exp_intr));
            check($sformatf("value[%0d]", i), 32'(value), 32'(vecs[i].exp_val));
            @(negedge clk);
            check($sformatf("intr_clear[%0d]", i), 32'(intr), 32'd0);
            prev_rep = vecs[i].exp_intr;
        end

        // Enable dropped mid-transaction: hold for Done, report, then stay disabled.
        wait_start(20, cyc, found);
        check("drop_start_found", 32'(found), 32'd1);
        @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("drop_hold_start_c%0d", k), 32'(start), 32'd0);
            check($sformatf("drop_hold_intr_c%0d", k), 32'(intr), 32'd0);
        end
        thr   = 16'h0000;
        byte1 = 8'h43;
        byte0 = 8'h21;
        done  = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("drop_intr", 32'(intr), 32'd1);
        check("drop_value", 32'(value), 32'h4321);
        @(negedge clk);
        check("drop_intr_clear", 32'(intr), 32'd0);
        snap = start_cnt;
        repeat (10) @(negedge clk);
        check("drop_no_restart", 32'(start_cnt), 32'(snap));

        // Preset 0 starts on the first stIdle cycle; then reset lands mid-transfer.
        preset_l = 16'd0;
        enable   = 1'b1;
        @(negedge clk);
        check("preset0_start", 32'(start), 32'd1);
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("midreset_intr", 32'(intr), 32'd0);
        check("midreset_start", 32'(start), 32'd0);
        check("midreset_value", 32'(value), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_no_start", 32'(start), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("post_reset_start", 32'(start), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        error = 1'b1;
        @(negedge clk);
        error = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
